// File: rtl/ldpc_ag_pkg.sv
// Shared state type, width helpers and configuration check for the QC-LDPC address generators.
package ldpc_ag_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int off_bits(input int z_max);
        return (z_max > 1) ? $clog2(z_max) : 1;
    endfunction

    function automatic int z_bits(input int z_max);
        return $clog2(z_max + 1);
    endfunction

    function automatic int blk_bits(input int max_blk);
        return (max_blk > 1) ? $clog2(max_blk) : 1;
    endfunction

    function automatic int nb_bits(input int max_blk);
        return $clog2(max_blk + 1);
    endfunction

    function automatic logic cfg_legal(input int z, input int nblk, input int z_max, input int max_blk);
        return (z >= 1) && (z <= z_max) && (nblk >= 1) && (nblk <= max_blk);
    endfunction

endpackage

// File: rtl/ldpc_mod_ctr.sv
// Modulo counter with load and enable; counts 0..last_val and wraps to 0.
module ldpc_mod_ctr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    logic [W-1:0] cnt;

    assign wrap = (cnt == last_val);

    // nxt is exported so the owner can register values derived from the upcoming count.
    always_comb begin
        if (load) begin
            nxt = load_val;
        end else if (en) begin
            nxt = wrap ? '0 : cnt + W'(1);
        end else begin
            nxt = cnt;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/ldpc_qc_ag.sv
// QC-LDPC block-row address generator: walks nblk circulants of size z, emitting base+((shift+k) mod z).
module ldpc_qc_ag
    import ldpc_ag_pkg::*;
#(
    parameter int Z_MAX     = 64,
    parameter int MAX_BLK   = 8,
    parameter int ADDR_BITS = 9,
    localparam int OFF_BITS = off_bits(Z_MAX),
    localparam int Z_BITS   = z_bits(Z_MAX),
    localparam int BLK_BITS = blk_bits(MAX_BLK),
    localparam int NB_BITS  = nb_bits(MAX_BLK)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [BLK_BITS-1:0]  cfg_idx,
    input  logic [OFF_BITS-1:0]  cfg_shift,
    input  logic [Z_BITS-1:0]    cfg_z,
    input  logic [NB_BITS-1:0]   cfg_nblk,
    input  logic                 start,
    input  logic                 enable,
    output logic [ADDR_BITS-1:0] address,
    output logic                 addr_valid,
    output logic [BLK_BITS-1:0]  blk_idx,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_e                state, state_d;
    logic [OFF_BITS-1:0]   shift_tbl [MAX_BLK];
    logic [Z_BITS-1:0]     z_r, z_d;
    logic [OFF_BITS-1:0]   z_m1;
    logic [BLK_BITS-1:0]   nblk_m1, nblk_m1_d, blk_d, blk_inc;
    logic [OFF_BITS-1:0]   k, k_d;
    logic [ADDR_BITS-1:0]  base, base_d, address_d;
    logic                  valid_d, last_d, busy_d, done_d, err_d;
    logic                  ctr_en, ctr_load;
    logic [OFF_BITS-1:0]   ctr_val, off_nxt;
    logic                  unused_wrap;

    function automatic logic shift_bad(input logic [OFF_BITS-1:0] sh, input logic [Z_BITS-1:0] z);
        return Z_BITS'(sh) >= z;
    endfunction

    assign z_m1    = OFF_BITS'(z_r - Z_BITS'(1));
    assign blk_inc = blk_idx + BLK_BITS'(1);

    ldpc_mod_ctr #(.W(OFF_BITS)) u_off (
        .clk      (clk),
        .reset    (reset),
        .en       (ctr_en),
        .load     (ctr_load),
        .load_val (ctr_val),
        .last_val (z_m1),
        .nxt      (off_nxt),
        .wrap     (unused_wrap)
    );

    // Counters hold on the final accept, so base+offset keeps presenting the final address.
    assign address_d = base_d + ADDR_BITS'(off_nxt);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        z_d       = z_r;
        nblk_m1_d = nblk_m1;
        base_d    = base;
        k_d       = k;
        blk_d     = blk_idx;
        valid_d   = addr_valid;
        last_d    = last;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = err;
        ctr_en    = 1'b0;
        ctr_load  = 1'b0;
        ctr_val   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_legal(int'(cfg_z), int'(cfg_nblk), Z_MAX, MAX_BLK)) begin
                        state_d   = RUN;
                        z_d       = cfg_z;
                        nblk_m1_d = BLK_BITS'(cfg_nblk - NB_BITS'(1));
                        base_d    = '0;
                        k_d       = '0;
                        blk_d     = '0;
                        ctr_load  = 1'b1;
                        err_d     = shift_bad(shift_tbl[0], cfg_z);
                        ctr_val   = err_d ? '0 : shift_tbl[0];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        last_d    = (cfg_z == Z_BITS'(1)) && (cfg_nblk == NB_BITS'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (enable) begin
                    if (last) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (k == z_m1) begin
                        blk_d    = blk_inc;
                        base_d   = base + ADDR_BITS'(z_r);
                        k_d      = '0;
                        ctr_load = 1'b1;
                        if (shift_bad(shift_tbl[blk_inc], z_r)) begin
                            err_d = 1'b1;
                        end else begin
                            ctr_val = shift_tbl[blk_inc];
                        end
                        last_d = (z_m1 == '0) && (blk_inc == nblk_m1);
                    end else begin
                        k_d    = k + OFF_BITS'(1);
                        ctr_en = 1'b1;
                        last_d = (k_d == z_m1) && (blk_idx == nblk_m1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            z_r        <= '0;
            nblk_m1    <= '0;
            base       <= '0;
            k          <= '0;
            address    <= '0;
            addr_valid <= 1'b0;
            blk_idx    <= '0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            z_r        <= z_d;
            nblk_m1    <= nblk_m1_d;
            base       <= base_d;
            k          <= k_d;
            address    <= address_d;
            addr_valid <= valid_d;
            blk_idx    <= blk_d;
            last       <= last_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // NOTE: the shift table is a small flop array and is reset so a fresh run never sees stale shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_BLK; i++) begin
                shift_tbl[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            shift_tbl[cfg_idx] <= cfg_shift;
        end
    end

endmodule

// File: tb/tb_ldpc_qc_ag.sv
// Scoreboard bench for ldpc_qc_ag: arithmetic reference model feeds a queue, a negedge monitor compares.
module tb_ldpc_qc_ag;

    localparam int Z_MAX     = 64;
    localparam int MAX_BLK   = 8;
    localparam int ADDR_BITS = 9;
    localparam int OFF_BITS  = 6;
    localparam int Z_BITS    = 7;
    localparam int BLK_BITS  = 3;
    localparam int NB_BITS   = 4;
    localparam int LIMIT     = 4000;

    typedef struct {
        int addr;
        int blk;
        bit last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [BLK_BITS-1:0]  cfg_idx = '0;
    logic [OFF_BITS-1:0]  cfg_shift = '0;
    logic [Z_BITS-1:0]    cfg_z = '0;
    logic [NB_BITS-1:0]   cfg_nblk = '0;
    logic                 start = 1'b0;
    logic                 enable = 1'b0;
    logic [ADDR_BITS-1:0] address;
    logic                 addr_valid;
    logic [BLK_BITS-1:0]  blk_idx;
    logic                 last;
    logic                 busy;
    logic                 done;
    logic                 err;

    ldpc_qc_ag #(.Z_MAX(Z_MAX), .MAX_BLK(MAX_BLK), .ADDR_BITS(ADDR_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_shift  (cfg_shift),
        .cfg_z      (cfg_z),
        .cfg_nblk   (cfg_nblk),
        .start      (start),
        .enable     (enable),
        .address    (address),
        .addr_valid (addr_valid),
        .blk_idx    (blk_idx),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   mshift[MAX_BLK];
    bit   exp_err = 1'b0;
    int   final_addr = 0;
    int   busy_cyc = 0;
    bit   en_manual = 1'b1;
    int   en_pct = 100;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented address must match the queue head; an accepted one retires it.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_cyc++;
            if (addr_valid) begin
                check("busy_with_valid", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_addr: got address %0d, expected no address", address);
                end else begin
                    check("address", int'(address), exp_q[0].addr);
                    check("blk_idx", int'(blk_idx), exp_q[0].blk);
                    check("last", int'(last), int'(exp_q[0].last));
                    if (enable) begin
                        final_addr = exp_q[0].addr;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!en_manual) enable = ($urandom_range(99) < en_pct);
        end
    end

    // All tasks below start and end one time unit after a rising edge.
    task automatic write_shift(input int idx, input int val, input bit model);
        cfg_we    = 1'b1;
        cfg_idx   = BLK_BITS'(idx);
        cfg_shift = OFF_BITS'(val);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (model) mshift[idx] = val;
    endtask

    task automatic issue(input int z, input int nblk);
        exp_err = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            int s;
            s = mshift[b];
            if (s >= z) begin
                exp_err = 1'b1;
                s = 0;
            end
            for (int kk = 0; kk < z; kk++) begin
                exp_q.push_back('{addr: b * z + (s + kk) % z, blk: b, last: (b == nblk - 1) && (kk == z - 1)});
            end
        end
        busy_cyc = 0;
        cfg_z    = Z_BITS'(z);
        cfg_nblk = NB_BITS'(nblk);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("valid_after_start", int'(addr_valid), 1);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic bad_start(input int z, input int nblk);
        cfg_z    = Z_BITS'(z);
        cfg_nblk = NB_BITS'(nblk);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("bad_cfg_err", int'(err), 1);
        check("bad_cfg_busy", int'(busy), 0);
        check("bad_cfg_valid", int'(addr_valid), 0);
    endtask

    task automatic wait_done(input bit b2b);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done not seen, expected within %0d cycles", LIMIT);
            exp_q.delete();
        end else begin
            check("done_busy", int'(busy), 0);
            check("done_valid", int'(addr_valid), 0);
            check("done_last", int'(last), 0);
            check("hold_final_addr", int'(address), final_addr);
            check("err_at_done", int'(err), int'(exp_err));
            check("queue_drained", exp_q.size(), 0);
            if (!b2b) begin
                @(posedge clk);
                #1;
                check("done_one_cycle", int'(done), 0);
                check("err_sticky", int'(err), int'(exp_err));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MAX_BLK; i++) mshift[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address", int'(address), 0);
        check("rst_valid", int'(addr_valid), 0);
        check("rst_blk", int'(blk_idx), 0);
        check("rst_last", int'(last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed z=4, nblk=2, shifts {1,3}: 1,2,3,0,7,4,5,6.
        enable = 1'b1;
        write_shift(0, 1, 1'b1);
        write_shift(1, 3, 1'b1);
        issue(4, 2);
        wait_done(1'b0);
        check("busy_cycles", busy_cyc, 8);

        // Stall two cycles after the second address.
        issue(4, 2);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stall_hold_addr", int'(address), 2);
            check("stall_hold_valid", int'(addr_valid), 1);
        end
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("after_stall_addr", int'(address), 3);
        wait_done(1'b0);

        // Illegal configurations, then a legal start clears err.
        bad_start(0, 2);
        bad_start(4, 9);
        bad_start(65, 1);
        issue(4, 2);
        check("err_cleared", int'(err), 0);
        wait_done(1'b0);

        // Out-of-range shift on block 1; a write while running must be ignored.
        write_shift(1, 5, 1'b1);
        issue(4, 2);
        write_shift(0, 2, 1'b0);
        wait_done(1'b0);
        issue(4, 2);
        check("err_cleared_rerun", int'(err), 0);
        wait_done(1'b0);

        // z=1: one address per block.
        for (int b = 0; b < 4; b++) write_shift(b, 0, 1'b1);
        issue(1, 4);
        wait_done(1'b0);

        // Full size row with random stalls, then a back-to-back start on done.
        en_manual = 1'b0;
        en_pct    = 70;
        for (int b = 0; b < MAX_BLK; b++) write_shift(b, 63, 1'b1);
        issue(64, 8);
        wait_done(1'b1);
        issue(3, 3);
        wait_done(1'b0);

        // Randomised rows.
        for (int r = 0; r < 6; r++) begin
            int z;
            int nb;
            z  = int'($urandom_range(1, Z_MAX));
            nb = int'($urandom_range(1, MAX_BLK));
            en_pct = int'($urandom_range(40, 100));
            for (int b = 0; b < nb; b++) begin
                int s;
                s = int'($urandom_range(0, z + 2));
                if (s > 63) s = 63;
                write_shift(b, s, 1'b1);
            end
            issue(z, nb);
            wait_done(1'b0);
        end

        // Reset on the third address aborts the run and clears the table.
        en_manual = 1'b1;
        enable    = 1'b1;
        write_shift(0, 1, 1'b1);
        write_shift(1, 3, 1'b1);
        issue(4, 2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("third_addr", int'(address), 3);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("abort_address", int'(address), 0);
        check("abort_valid", int'(addr_valid), 0);
        check("abort_blk", int'(blk_idx), 0);
        check("abort_last", int'(last), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_err", int'(err), 0);
        @(posedge clk);
        #1;
        check("abort_no_done", int'(done), 0);
        reset = 1'b1;
        for (int i = 0; i < MAX_BLK; i++) mshift[i] = 0;
        @(posedge clk);
        #1;
        check("abort_no_done_late", int'(done), 0);
        issue(4, 2);
        wait_done(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ldpc_qc_ag.md
Name: ldpc_qc_ag

Overview:
Parametrised successor to the plain enable/reset address counter. It is a quasi-cyclic LDPC address generator that walks one block row of up to MAX_BLK circulant sub-matrices, each of runtime size z (at most Z_MAX). For each circulant it emits the z memory addresses base+((shift+k) mod z), k=0..z-1, under a start/busy/done handshake with a stall (enable) input. It sits between the decoder schedule controller and the variable-node/LLR memories.

Parameters:
Z_MAX, 64, largest supported circulant size (expansion factor)
MAX_BLK, 8, largest number of circulants per block row
ADDR_BITS, 9, address width; must satisfy 2**ADDR_BITS >= MAX_BLK*Z_MAX
(derived localparams: OFF_BITS=clog2(Z_MAX), Z_BITS=clog2(Z_MAX+1), BLK_BITS=clog2(MAX_BLK), NB_BITS=clog2(MAX_BLK+1))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  write one shift-table entry
cfg_idx  in  BLK_BITS  shift-table index
cfg_shift  in  OFF_BITS  circulant shift value
cfg_z  in  Z_BITS  circulant size, sampled on accepted start
cfg_nblk  in  NB_BITS  circulants in row, sampled on accepted start
start  in  1  begin a sequence (level-sampled while IDLE)
enable  in  1  consumer accepts current address (stall when 0)
address  out  ADDR_BITS  current address
addr_valid  out  1  address is valid
blk_idx  out  BLK_BITS  circulant index of current address
last  out  1  current address is final of sequence
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after last address accepted
err  out  1  sticky configuration error

Behaviour:
- Reset (reset=0, async): address=0, addr_valid=0, blk_idx=0, last=0, busy=0, done=0, err=0, all shift-table entries=0, state IDLE.
- Shift table: MAX_BLK x OFF_BITS registers. A write occurs on a clock edge when cfg_we=1 and state is IDLE. Writes while busy are ignored.
- States: IDLE, RUN. All outputs registered.
- IDLE, start=1, legal config (1<=cfg_z<=Z_MAX, 1<=cfg_nblk<=MAX_BLK):
  - latch z and nblk; clear err; go to RUN.
  - next cycle: busy=1, addr_valid=1, blk_idx=0, address=off0, where off0=shift[0].
- IDLE, start=1, illegal config: err=1, remain IDLE, busy stays 0.
- Handshake: address/addr_valid hold until a cycle with enable=1. enable=0 freezes every output and counter.
- Accepted address advances the per-block offset: off = (off==z-1) ? 0 : off+1; k++.
- When k==z-1 is accepted:
  - blk_idx++ and base += z (running adder; no multiplier).
  - off loads the next block's shift.
  - if that shift >= z: err=1 and off loads 0 (sequence continues).
- address = base + off, using an ADDR_BITS-wide add.
- last=1 exactly while the presented address has k==z-1 and blk_idx==nblk-1.
- Accepting the last address: next cycle RUN->IDLE, addr_valid=0, busy=0, last=0, done=1 for one cycle; address holds its final value.
- start during RUN is ignored. start in the same cycle that done is high is accepted (back-to-back allowed).
- z=1: each block emits one address (base), and last pulses every block only on the final one.
- Reset asserted mid-run aborts immediately to the reset values; no done pulse.
- Latency: first address 1 cycle after start; throughput 1 address/cycle with enable held high; total nblk*z accepted cycles.

Decomposition:
- Package ldpc_ag_pkg:
  - state enum (IDLE, RUN)
  - clog2-based width functions for OFF_BITS, Z_BITS, BLK_BITS, NB_BITS
  - config legality check function
- Sub-module ldpc_mod_ctr: modulo-z offset counter with load, enable and wrap flag. It is instantiated once and reused by future column-schedule generators.

Test Plan:
- z=4, nblk=2, shift={1,3}, enable=1 -> addresses 1,2,3,0,7,4,5,6; last on 6; done pulse next cycle; busy high for exactly 8 cycles.
- Same config, enable=0 for 2 cycles after second address -> address holds 2 with addr_valid=1 for 3 cycles, then 3,0,...; total sequence unchanged.
- start with cfg_z=0, then with cfg_nblk=9 -> err=1, busy=0, addr_valid=0; then a legal start -> err cleared and sequence runs.
- z=4, shift[1]=5 (>=z) -> block 1 emits 4,5,6,7 and err=1 sticky; cfg_we during RUN does not alter the table (verify on rerun).
- z=64, nblk=8, all shifts=63 -> 512 addresses, first 63, block 7 starts at 511 then 448; no out-of-range address; back-to-back start on done accepted.
- Reset low at 3rd address of a run -> outputs immediately 0, no done pulse; shift table cleared to 0.
